accel_spi_sampler: RTL and testbench

//  Upstream feeder for the ball-position stage. SPI master for the on-board ADXL362

---
 rtl/accel_pkg.sv | 15 +
 rtl/spi_byte_xfer.sv | 61 ++++++
 rtl/accel_spi_sampler.sv | 115 +++++++++++
 tb/tb_accel_spi_sampler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// accel_pkg: ADXL362 command constants and sampler FSM encoding
package accel_pkg;
  localparam logic [7:0] OP_WRITE          = 8'h0A;
  localparam logic [7:0] OP_READ           = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL     = 8'h2D;
  localparam logic [7:0] REG_XDATA         = 8'h08;
  localparam logic [7:0] POWER_CTL_MEASURE = 8'h02;
  typedef enum logic [2:0] {
    S_WAIT_START, S_INIT, S_GAP, S_IDLE, S_READ, S_UPDATE
  } state_t;
  function automatic logic [7:0] frame_byte(input logic rd, input logic [1:0] idx);
    return rd ? (idx == 2'd0 ? OP_READ : idx == 2'd1 ? REG_XDATA : 8'h00)
              : (idx == 2'd0 ? OP_WRITE : idx == 2'd1 ? REG_POWER_CTL : POWER_CTL_MEASURE);
  endfunction
endpackage

// File: rtl/spi_byte_xfer.sv
// spi_byte_xfer: one-byte SPI mode-0 shifter, MSB first, HALF clks per SCLK half period
module spi_byte_xfer #(
  parameter int HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_tx,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rx
);
  localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh, r_rx;
  logic          r_sclk, r_busy, r_done;
  logic          w_edge;
  assign w_edge = r_busy && r_cnt == CW'(HALF - 1);
  assign o_sclk = r_sclk;
  assign o_mosi = r_sh[7];
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_rx   = r_rx;
  // rising SCLK samples MISO, falling SCLK advances MOSI; the byte ends on the 8th fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt  <= '0;
      r_bit  <= '0;
      r_sh   <= '0;
      r_rx   <= '0;
      r_sclk <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_busy <= 1'b1;
        r_sh   <= i_tx;
        r_cnt  <= '0;
        r_bit  <= '0;
      end else if (r_busy) begin
        r_cnt <= w_edge ? '0 : r_cnt + 1'b1;
        if (w_edge) begin
          r_sclk <= !r_sclk;
          if (!r_sclk) r_rx <= {r_rx[6:0], i_miso};
          else if (r_bit == 3'd7) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_sh   <= '0;
          end else begin
            r_bit <= r_bit + 3'd1;
            r_sh  <= {r_sh[6:0], 1'b0};
          end
        end
      end
    end
endmodule

// File: rtl/accel_spi_sampler.sv
// accel_spi_sampler: ADXL362 SPI master that configures measurement mode, then
// periodically reads X/Y, converts to offset binary and moving-averages them.
module accel_spi_sampler
  import accel_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ    = 100000000,
  parameter int SCLK_FREQUENCY_HZ   = 1000000,
  parameter int SAMPLE_FREQUENCY_HZ = 100,
  parameter int STARTUP_CYCLES      = 500000,
  parameter int AVG_LOG2            = 2,
  parameter int SIMULATE            = 0,
  parameter int SIMULATE_SAMPLE_CNT = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_csn,
  output logic [7:0] accelX_out,
  output logic [7:0] accelY_out,
  output logic       sample_valid,
  output logic       init_done
);
  localparam int HALF_RAW   = CLK_FREQUENCY_HZ / (2 * SCLK_FREQUENCY_HZ);
  localparam int HALF       = HALF_RAW < 1 ? 1 : HALF_RAW;
  localparam int SAMPLE_CNT = SIMULATE != 0 ? SIMULATE_SAMPLE_CNT : CLK_FREQUENCY_HZ / SAMPLE_FREQUENCY_HZ;
  localparam int START_CNT  = SIMULATE != 0 ? 16 : STARTUP_CYCLES;
  localparam int GAP_CNT    = 2 * HALF;
  localparam int N          = 1 << AVG_LOG2;
  localparam int SW         = 8 + AVG_LOG2;
  state_t        r_state, w_next;
  logic [31:0]   r_wcnt, r_tcnt;
  logic [1:0]    r_byte;
  logic          r_kick, r_pend, r_init;
  logic [7:0]    r_rawx, r_rawy;
  logic [7:0]    r_hx [N];
  logic [7:0]    r_hy [N];
  logic [SW-1:0] r_sx, r_sy, w_sx, w_sy;
  logic          w_tick, w_busy, w_done, w_last, w_xfer_next;
  logic [7:0]    w_rx;
  assign w_tick      = r_tcnt == 32'(SAMPLE_CNT - 1);
  assign w_last      = r_byte == (r_state == S_READ ? 2'd3 : 2'd2);
  assign w_xfer_next = w_next == S_INIT || w_next == S_READ;
  assign spi_csn     = !(r_state == S_INIT || r_state == S_READ);
  assign init_done   = r_init;
  assign w_sx        = r_sx + SW'(r_rawx ^ 8'h80) - SW'(r_hx[N-1]);
  assign w_sy        = r_sy + SW'(r_rawy ^ 8'h80) - SW'(r_hy[N-1]);
  spi_byte_xfer #(.HALF(HALF)) u_xfer (
    .clk(clk), .rst(reset), .i_start(r_kick && !w_busy),
    .i_tx(frame_byte(r_state == S_READ, r_byte)), .i_miso(spi_miso),
    .o_sclk(spi_sclk), .o_mosi(spi_mosi), .o_busy(w_busy), .o_done(w_done), .o_rx(w_rx)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_START: if (r_wcnt == 32'(START_CNT - 1)) w_next = S_INIT;
      S_INIT:       if (w_done && w_last) w_next = S_GAP;
      S_GAP:        if (r_wcnt == 32'(GAP_CNT - 1)) w_next = S_IDLE;
      S_IDLE:       if (w_tick || r_pend) w_next = S_READ;
      S_READ:       if (w_done && w_last) w_next = S_UPDATE;
      S_UPDATE:     w_next = S_GAP;
      default:      w_next = S_WAIT_START;
    endcase
  end
  // a tick outside IDLE is remembered once and served when the FSM returns to IDLE
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_WAIT_START;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
      r_byte  <= '0;
      r_kick  <= 1'b0;
      r_pend  <= 1'b0;
      r_init  <= 1'b0;
      r_rawx  <= '0;
      r_rawy  <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_next != r_state ? '0 : r_wcnt + 32'd1;
      r_tcnt  <= w_tick ? '0 : r_tcnt + 32'd1;
      r_pend  <= r_state == S_IDLE ? 1'b0 : r_pend || (w_tick && r_state != S_WAIT_START);
      r_kick  <= (w_xfer_next && w_next != r_state) || (w_done && !w_last);
      r_byte  <= w_next != r_state ? 2'd0 : r_byte + 2'(w_done);
      r_init  <= r_init || (r_state == S_INIT && w_next == S_GAP);
      if (r_state == S_READ && w_done && r_byte == 2'd2) r_rawx <= w_rx;
      if (r_state == S_READ && w_done && r_byte == 2'd3) r_rawy <= w_rx;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_hx[i] <= 8'h80;
        r_hy[i] <= 8'h80;
      end
      r_sx         <= SW'(128 << AVG_LOG2);
      r_sy         <= SW'(128 << AVG_LOG2);
      accelX_out   <= 8'h80;
      accelY_out   <= 8'h80;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= r_state == S_UPDATE;
      if (r_state == S_UPDATE) begin
        r_hx[0] <= r_rawx ^ 8'h80;
        r_hy[0] <= r_rawy ^ 8'h80;
        for (int i = N - 1; i > 0; i--) begin
          r_hx[i] <= r_hx[i-1];
          r_hy[i] <= r_hy[i-1];
        end
        r_sx       <= w_sx;
        r_sy       <= w_sy;
        accelX_out <= 8'(w_sx >> AVG_LOG2);
        accelY_out <= 8'(w_sy >> AVG_LOG2);
      end
    end
endmodule

// File: tb/tb_accel_spi_sampler.sv
// tb_accel_spi_sampler: directed checks of three sampler instances, each with an ADXL362 slave model
module tb_accel_spi_sampler;
  logic clk = 1'b0;
  logic [2:0] rst;
  logic [7:0] xv [3];
  logic [7:0] yv [3];
  wire  [2:0] csn, sclk, mosi, sv, idn;
  wire  [2:0][7:0] ax, ay;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_b [5] = '{8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hC0};
  always #5 clk = ~clk;

  // instance 0: AVG_LOG2=0; 1: AVG_LOG2=2; 2: sample period shorter than a read
  for (genvar g = 0; g < 3; g++) begin : gs
    logic mi = 1'b0, pc = 1'b1, ps = 1'b0, last_rd = 1'b0;
    int n = 0, hi = 0, vc = 0, rc = 0, ln = 0, mingap = 1000000, maxgap = 0;
    logic [31:0] sh = '0, lf = '0, fo;
    assign fo = {16'h0000, xv[g], yv[g]};
    accel_spi_sampler #(
      .SCLK_FREQUENCY_HZ(10000000), .AVG_LOG2(g == 1 ? 2 : 0), .SIMULATE(1),
      .SIMULATE_SAMPLE_CNT(g == 2 ? 200 : 1000)
    ) dut (
      .clk(clk), .reset(rst[g]), .spi_miso(mi), .spi_sclk(sclk[g]), .spi_mosi(mosi[g]),
      .spi_csn(csn[g]), .accelX_out(ax[g]), .accelY_out(ay[g]), .sample_valid(sv[g]),
      .init_done(idn[g])
    );
    always @(negedge clk) begin
      if (sv[g]) vc++;
      if (pc && !csn[g]) begin
        if (last_rd) begin
          mingap = hi < mingap ? hi : mingap;
          maxgap = hi > maxgap ? hi : maxgap;
        end
        n = 0;
        sh = '0;
        mi = fo[31];
      end else if (!csn[g] && ps && !sclk[g] && n < 32) mi = fo[31 - n];
      if (!csn[g] && !ps && sclk[g]) begin
        sh = {sh[30:0], mosi[g]};
        n++;
      end
      if (!pc && csn[g]) begin
        lf = sh;
        ln = n;
        last_rd = n == 32;
        if (n == 32) rc++;
        hi = 0;
      end
      if (csn[g]) hi++;
      pc = csn[g];
      ps = sclk[g];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cs(input int g, input logic lvl, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      #1 hit = csn[g] == lvl;
    end
    check(tag, 32'(hit), 1);
  endtask

  task automatic wait_sv(input int g, input int budget, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk);
      #1 hit = sv[g];
    end
    check(tag, 32'(hit), 1);
  endtask

  initial begin
    int seen, vc0;
    logic p;
    rst = '1;
    xv = '{8'h10, 8'h00, 8'h25};
    yv = '{8'hF0, 8'h00, 8'hC3};
    repeat (3) @(posedge clk);
    #1;
    check("rst_csn", csn[0], 1);
    check("rst_sclk", sclk[0], 0);
    check("rst_mosi", mosi[0], 0);
    check("rst_x", ax[0], 8'h80);
    check("rst_y", ay[1], 8'h80);
    check("rst_valid", sv[0], 0);
    check("rst_init_done", idn[0], 0);
    @(negedge clk) rst = '0;
    repeat (15) @(posedge clk);
    #1 check("csn_before_16", csn[0], 1);
    @(posedge clk);
    #1 check("csn_at_16", csn[0], 0);
    check("init_done_during_init", idn[0], 0);
    wait_cs(0, 1'b1, 400, "init_end");
    check("init_done", idn[0], 1);
    @(negedge clk);
    #1;
    check("init_bits", gs[0].ln, 24);
    check("init_frame", gs[0].lf, 32'h000A2D02);

    wait_sv(0, 1500, "rd1_valid");
    check("rd1_x", ax[0], 8'h90);
    check("rd1_y", ay[0], 8'h70);
    check("avg_x_level", ax[1], 8'h80);
    check("avg_y_level", ay[1], 8'h80);
    check("rd1_cmd", gs[0].lf[31:16], 16'h0B08);
    check("rd1_bits", gs[0].ln, 32);
    @(posedge clk);
    #1 check("rd1_pulse_width", sv[0], 0);
    check("rd1_pulse_count", gs[0].vc, 1);

    xv[0] = 8'h7F;
    yv[0] = 8'h80;
    xv[1] = 8'h40;
    for (int k = 0; k < 5; k++) begin
      wait_sv(1, 1500, "avg_valid");
      check("avg_x_step", ax[1], exp_b[k]);
      check("ext_x", ax[0], 8'hFF);
      check("ext_y", ay[0], 8'h00);
    end
    repeat (20) @(posedge clk);
    #1 check("hold_x", ax[1], 8'hC0);
    check("hold_valid", sv[1], 0);

    wait_sv(2, 1000, "bb_valid");
    @(negedge clk);
    #1;
    check("bb_one_valid_per_read", gs[2].vc, gs[2].rc);
    check("bb_min_gap_ge_10", 32'(gs[2].mingap >= 10), 1);
    check("bb_back_to_back", 32'(gs[2].maxgap <= 20), 1);
    check("bb_read_count", 32'(gs[2].rc >= 12), 1);
    check("bb_x", ax[2], 8'hA5);
    check("bb_y", ay[2], 8'h43);

    wait_cs(0, 1'b0, 1500, "rst_read_start");
    seen = 0;
    p = 1'b0;
    for (int i = 0; i < 300 && seen < 12; i++) begin
      @(posedge clk);
      #1 if (sclk[0] && !p) seen++;
      p = sclk[0];
    end
    check("rst_sclk_rises", seen, 12);
    vc0 = gs[0].vc;
    #2 rst[0] = 1'b1;
    #1;
    check("midrst_csn", csn[0], 1);
    check("midrst_sclk", sclk[0], 0);
    check("midrst_x", ax[0], 8'h80);
    check("midrst_y", ay[0], 8'h80);
    check("midrst_valid", sv[0], 0);
    check("midrst_init_done", idn[0], 0);
    repeat (5) @(posedge clk);
    #1 check("midrst_no_pulse", gs[0].vc, vc0);
    @(negedge clk) rst[0] = 1'b0;
    repeat (15) @(posedge clk);
    #1 check("reinit_csn_before_16", csn[0], 1);
    @(posedge clk);
    #1 check("reinit_csn_at_16", csn[0], 0);
    wait_cs(0, 1'b1, 400, "reinit_end");
    check("reinit_done", idn[0], 1);
    check("reinit_x_untouched", ax[0], 8'h80);
    @(negedge clk);
    #1;
    check("reinit_bits", gs[0].ln, 24);
    check("reinit_frame", gs[0].lf, 32'h000A2D02);
    check("reinit_no_pulse", gs[0].vc, vc0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
